// File: rtl/wb_commit_pkg.sv
// Shared definitions for the writeback/commit slice.
// Holds the datapath width, node geometry, status flag bit positions,
// the register code that aliases the node register rn, the stack pointer
// reset value and the opcode constants used by the surrounding pipeline.
package wb_commit_pkg;

    localparam int WORD       = 32;
    localparam int NODE_BITS  = 8;
    localparam int NODES      = 1 << NODE_BITS;
    localparam int VIS_OFFSET = 32'h0000_0100;

    // Status register flag bit positions.
    localparam int Zf = 0;
    localparam int Cf = 1;
    localparam int Nf = 2;
    localparam int If = 3;

    localparam logic [2:0]      RN_CODE  = 3'd7;
    localparam logic [WORD-1:0] SP_RESET = 32'h0000_0000;

    // Opcode constants.
    localparam logic [4:0] OP_NOP  = 5'd0;
    localparam logic [4:0] OP_ADDI = 5'd1;
    localparam logic [4:0] OP_SCN  = 5'd2;
    localparam logic [4:0] OP_STEP = 5'd3;
    localparam logic [4:0] OP_JMP  = 5'd4;
    localparam logic [4:0] OP_RJMP = 5'd5;
    localparam logic [4:0] OP_PUSH = 5'd6;
    localparam logic [4:0] OP_POP  = 5'd7;

endpackage

// File: rtl/wb_mem_fifo.sv
// Circular write queue with a 2-wide push and a 1-wide pop.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   push0, din0      first push (lands at the tail)
//   push1, din1      second push (lands after din0 when both are set)
//   dout             head entry, valid whenever count != 0
//   count            occupied entries, 0..DEPTH
// The head pops every cycle the queue is non-empty (the consumer never
// stalls). The caller guarantees free space for every push.
module wb_mem_fifo
    import wb_commit_pkg::*;
#(
    parameter int W     = 64,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push0,
    input  logic [W-1:0]  din0,
    input  logic          push1,
    input  logic [W-1:0]  din1,
    output logic [W-1:0]  dout,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] wr_idx;
    logic          pop;

    always_comb begin
        mem_d    = mem_q;
        wr_idx   = wr_ptr_q;
        pop      = (count_q != '0);
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        // Pointers are AW bits wide, so the increments wrap modulo DEPTH.
        if (push0) begin
            mem_d[wr_idx] = din0;
            wr_idx        = wr_idx + AW'(1);
        end
        if (push1) begin
            mem_d[wr_idx] = din1;
            wr_idx        = wr_idx + AW'(1);
        end
        wr_ptr_d = wr_idx;
        count_d  = count_q + CW'(push0) + CW'(push1) - CW'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/wb_commit.sv
// Writeback/commit stage. Commits each accepted execute result to the
// architectural state and serialises up to two memory writes per
// instruction onto a single-port data memory through wb_mem_fifo.
// Ports:
//   in_valid / in_ready          upstream handshake
//   reg_*, rn_*, sp_*, flag_update/sreg_val, mem_*, mem_*2, jump/rjump/pc_*
//                                request fields, sampled only on accept
//   rf_we/rf_waddr/rf_wdata      registered register-file write pulse
//   rn_q, sp_q, sreg_q           committed architectural registers
//   pc_redirect/pc_abs/pc_target one-cycle redirect pulse
//   dmem_we/dmem_addr/dmem_wdata data memory write port (queue head)
// Handshake: a transfer happens on a rising edge where in_valid && in_ready.
// in_ready depends only on queue occupancy, never on in_valid; while it is
// low the upstream holds its fields stable.
module wb_commit #(
    parameter int               WORD     = wb_commit_pkg::WORD,
    parameter int               DEPTH    = 4,
    parameter logic [2:0]       RN_CODE  = wb_commit_pkg::RN_CODE,
    parameter logic [WORD-1:0]  SP_RESET = wb_commit_pkg::SP_RESET
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            reg_wb,
    input  logic [2:0]      reg_code,
    input  logic [WORD-1:0] reg_val,
    input  logic            rn_wb,
    input  logic [WORD-1:0] rn_val,
    input  logic            sp_wb,
    input  logic [WORD-1:0] sp_val,
    input  logic            flag_update,
    input  logic [WORD-1:0] sreg_val,
    input  logic            mem_wb,
    input  logic [WORD-1:0] mem_addr,
    input  logic [WORD-1:0] mem_val,
    input  logic            mem_wb2,
    input  logic [WORD-1:0] mem_addr2,
    input  logic [WORD-1:0] mem_val2,
    input  logic            jump,
    input  logic            rjump,
    input  logic [WORD-1:0] pc_loc,
    input  logic [WORD-1:0] pc_inc,
    output logic            rf_we,
    output logic [2:0]      rf_waddr,
    output logic [WORD-1:0] rf_wdata,
    output logic [WORD-1:0] rn_q,
    output logic [WORD-1:0] sp_q,
    output logic [WORD-1:0] sreg_q,
    output logic            pc_redirect,
    output logic            pc_abs,
    output logic [WORD-1:0] pc_target,
    output logic            dmem_we,
    output logic [WORD-1:0] dmem_addr,
    output logic [WORD-1:0] dmem_wdata
);
    import wb_commit_pkg::*;

    localparam int CW = $clog2(DEPTH + 1);

    logic            accept;
    logic [CW-1:0]   fifo_count;
    logic [2*WORD-1:0] fifo_head;

    logic            rf_we_q, rf_we_d;
    logic [2:0]      rf_waddr_q, rf_waddr_d;
    logic [WORD-1:0] rf_wdata_q, rf_wdata_d;
    logic [WORD-1:0] rn_d, sp_d, sreg_d;
    logic            pc_redirect_q, pc_redirect_d;
    logic            pc_abs_q, pc_abs_d;
    logic [WORD-1:0] pc_target_q, pc_target_d;

    // Ready only when a worst-case (two-write) instruction fits.
    assign in_ready = (32'(fifo_count) + 32'd2 <= 32'(DEPTH));
    assign accept   = in_valid && in_ready;

    wb_mem_fifo #(
        .W     (2 * WORD),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push0 (accept && mem_wb),
        .din0  ({mem_addr, mem_val}),
        .push1 (accept && mem_wb2),
        .din1  ({mem_addr2, mem_val2}),
        .dout  (fifo_head),
        .count (fifo_count)
    );

    assign dmem_we    = (fifo_count != '0);
    assign dmem_addr  = fifo_head[2*WORD-1:WORD];
    assign dmem_wdata = fifo_head[WORD-1:0];

    always_comb begin
        rf_we_d       = 1'b0;
        rf_waddr_d    = rf_waddr_q;
        rf_wdata_d    = rf_wdata_q;
        rn_d          = rn_q;
        sp_d          = sp_q;
        sreg_d        = sreg_q;
        pc_redirect_d = 1'b0;
        pc_abs_d      = pc_abs_q;
        pc_target_d   = pc_target_q;
        if (accept) begin
            if (reg_wb && reg_code != RN_CODE) begin
                rf_we_d    = 1'b1;
                rf_waddr_d = reg_code;
                rf_wdata_d = reg_val;
            end
            // An explicit rn write overrides an aliased register write.
            if (rn_wb)
                rn_d = rn_val;
            else if (reg_wb && reg_code == RN_CODE)
                rn_d = reg_val;
            if (sp_wb)
                sp_d = sp_val;
            if (flag_update)
                sreg_d = sreg_val;
            if (jump) begin
                pc_redirect_d = 1'b1;
                pc_abs_d      = 1'b1;
                pc_target_d   = pc_loc;
            end else if (rjump) begin
                pc_redirect_d = 1'b1;
                pc_abs_d      = 1'b0;
                pc_target_d   = pc_inc;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we_q       <= 1'b0;
            rf_waddr_q    <= '0;
            rf_wdata_q    <= '0;
            rn_q          <= '0;
            sp_q          <= SP_RESET;
            sreg_q        <= '0;
            pc_redirect_q <= 1'b0;
            pc_abs_q      <= 1'b0;
            pc_target_q   <= '0;
        end else begin
            rf_we_q       <= rf_we_d;
            rf_waddr_q    <= rf_waddr_d;
            rf_wdata_q    <= rf_wdata_d;
            rn_q          <= rn_d;
            sp_q          <= sp_d;
            sreg_q        <= sreg_d;
            pc_redirect_q <= pc_redirect_d;
            pc_abs_q      <= pc_abs_d;
            pc_target_q   <= pc_target_d;
        end
    end

    assign rf_we       = rf_we_q;
    assign rf_waddr    = rf_waddr_q;
    assign rf_wdata    = rf_wdata_q;
    assign pc_redirect = pc_redirect_q;
    assign pc_abs      = pc_abs_q;
    assign pc_target   = pc_target_q;

endmodule

// File: tb/tb_wb_commit.sv
// Bench for wb_commit: directed cases plus a randomised stream, with a
// scoreboard queue of expected {addr, data} memory writes.
module tb_wb_commit;

    localparam int W = 32;

    typedef struct packed {
        logic         reg_wb;
        logic [2:0]   reg_code;
        logic [W-1:0] reg_val;
        logic         rn_wb;
        logic [W-1:0] rn_val;
        logic         sp_wb;
        logic [W-1:0] sp_val;
        logic         flag_update;
        logic [W-1:0] sreg_val;
        logic         mem_wb;
        logic [W-1:0] mem_addr;
        logic [W-1:0] mem_val;
        logic         mem_wb2;
        logic [W-1:0] mem_addr2;
        logic [W-1:0] mem_val2;
        logic         jump;
        logic         rjump;
        logic [W-1:0] pc_loc;
        logic [W-1:0] pc_inc;
    } instr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic in_ready;
    logic reg_wb, rn_wb, sp_wb, flag_update, mem_wb, mem_wb2, jump, rjump;
    logic [2:0] reg_code;
    logic [W-1:0] reg_val, rn_val, sp_val, sreg_val, mem_addr, mem_val;
    logic [W-1:0] mem_addr2, mem_val2, pc_loc, pc_inc;
    logic rf_we, pc_redirect, pc_abs, dmem_we;
    logic [2:0] rf_waddr;
    logic [W-1:0] rf_wdata, rn_q, sp_q, sreg_q, pc_target, dmem_addr, dmem_wdata;

    logic [2*W-1:0] exp_q[$];
    int checks = 0;
    int failures = 0;
    int stall_cnt = 0;

    wb_commit dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .reg_wb(reg_wb), .reg_code(reg_code), .reg_val(reg_val),
        .rn_wb(rn_wb), .rn_val(rn_val), .sp_wb(sp_wb), .sp_val(sp_val),
        .flag_update(flag_update), .sreg_val(sreg_val),
        .mem_wb(mem_wb), .mem_addr(mem_addr), .mem_val(mem_val),
        .mem_wb2(mem_wb2), .mem_addr2(mem_addr2), .mem_val2(mem_val2),
        .jump(jump), .rjump(rjump), .pc_loc(pc_loc), .pc_inc(pc_inc),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .rn_q(rn_q), .sp_q(sp_q), .sreg_q(sreg_q),
        .pc_redirect(pc_redirect), .pc_abs(pc_abs), .pc_target(pc_target),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply(input instr_t ins);
        reg_wb = ins.reg_wb;   reg_code = ins.reg_code; reg_val = ins.reg_val;
        rn_wb = ins.rn_wb;     rn_val = ins.rn_val;
        sp_wb = ins.sp_wb;     sp_val = ins.sp_val;
        flag_update = ins.flag_update; sreg_val = ins.sreg_val;
        mem_wb = ins.mem_wb;   mem_addr = ins.mem_addr; mem_val = ins.mem_val;
        mem_wb2 = ins.mem_wb2; mem_addr2 = ins.mem_addr2; mem_val2 = ins.mem_val2;
        jump = ins.jump;       rjump = ins.rjump;
        pc_loc = ins.pc_loc;   pc_inc = ins.pc_inc;
    endtask

    // Called at a negedge; returns at the negedge of cycle t+1 after accept.
    task automatic send(input instr_t ins);
        int waited = 0;
        apply(ins);
        in_valid = 1'b1;
        while (!in_ready && waited < 20) begin
            stall_cnt++;
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            check_eq("accept_timeout", {63'd0, in_ready}, 64'd1);
            in_valid = 1'b0;
            return;
        end
        if (ins.mem_wb)  exp_q.push_back({ins.mem_addr, ins.mem_val});
        if (ins.mem_wb2) exp_q.push_back({ins.mem_addr2, ins.mem_val2});
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        instr_t z = '0;
        in_valid = 1'b0;
        apply(z);
        repeat (n) @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        idle(0);
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain", 64'(exp_q.size()), 64'd0);
        idle(1);
        check_eq("drained_we", {63'd0, dmem_we}, 64'd0);
    endtask

    // Scoreboard: every memory write on the port must match the oldest expected one.
    always @(negedge clk) begin
        if (!rst && dmem_we) begin
            if (exp_q.size() == 0) begin
                check_eq("dmem_spurious", {63'd0, dmem_we}, 64'd0);
            end else begin
                check_eq("dmem_write", {dmem_addr, dmem_wdata}, exp_q.pop_front());
            end
        end
    end

    initial begin
        instr_t ins;
        logic exp_we;
        idle(0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_eq("rst_rf_we", {63'd0, rf_we}, 64'd0);
        check_eq("rst_rf_waddr", 64'(rf_waddr), 64'd0);
        check_eq("rst_rf_wdata", 64'(rf_wdata), 64'd0);
        check_eq("rst_rn", 64'(rn_q), 64'd0);
        check_eq("rst_sp", 64'(sp_q), 64'd0);
        check_eq("rst_sreg", 64'(sreg_q), 64'd0);
        check_eq("rst_pc_redirect", {63'd0, pc_redirect}, 64'd0);
        check_eq("rst_pc_abs", {63'd0, pc_abs}, 64'd0);
        check_eq("rst_pc_target", 64'(pc_target), 64'd0);
        check_eq("rst_dmem_we", {63'd0, dmem_we}, 64'd0);
        check_eq("rst_in_ready", {63'd0, in_ready}, 64'd1);

        // ADDI-style register write
        ins = '0; ins.reg_wb = 1; ins.reg_code = 3'd2; ins.reg_val = 32'd5;
        send(ins);
        check_eq("addi_we", {63'd0, rf_we}, 64'd1);
        check_eq("addi_waddr", 64'(rf_waddr), 64'd2);
        check_eq("addi_wdata", 64'(rf_wdata), 64'd5);
        idle(1);
        check_eq("addi_we_pulse", {63'd0, rf_we}, 64'd0);

        // STEP traverse: two memory writes, sp and rn
        ins = '0;
        ins.mem_wb = 1;  ins.mem_addr = 32'h105; ins.mem_val = 32'h1;
        ins.mem_wb2 = 1; ins.mem_addr2 = 32'h21; ins.mem_val2 = 32'h8000;
        ins.sp_wb = 1;   ins.sp_val = 32'h21;
        ins.rn_wb = 1;   ins.rn_val = 32'h0002_8000;
        send(ins);
        check_eq("step_we1", {63'd0, dmem_we}, 64'd1);
        check_eq("step_wr1", {dmem_addr, dmem_wdata}, {32'h105, 32'h1});
        check_eq("step_sp", 64'(sp_q), 64'h21);
        check_eq("step_rn", 64'(rn_q), 64'h0002_8000);
        idle(1);
        check_eq("step_we2", {63'd0, dmem_we}, 64'd1);
        check_eq("step_wr2", {dmem_addr, dmem_wdata}, {32'h21, 32'h8000});
        drain();

        // Status register
        ins = '0; ins.flag_update = 1; ins.sreg_val = 32'hA5A5_000F;
        send(ins);
        check_eq("sreg", 64'(sreg_q), 64'hA5A5_000F);
        idle(1);

        // Redirects: jump beats rjump; rjump alone is relative
        ins = '0; ins.jump = 1; ins.rjump = 1; ins.pc_loc = 32'h40; ins.pc_inc = 32'h1;
        send(ins);
        check_eq("jmp_redirect", {63'd0, pc_redirect}, 64'd1);
        check_eq("jmp_abs", {63'd0, pc_abs}, 64'd1);
        check_eq("jmp_target", 64'(pc_target), 64'h40);
        idle(1);
        check_eq("jmp_pulse", {63'd0, pc_redirect}, 64'd0);
        ins = '0; ins.rjump = 1; ins.pc_loc = 32'h77; ins.pc_inc = 32'h1;
        send(ins);
        check_eq("rjmp_redirect", {63'd0, pc_redirect}, 64'd1);
        check_eq("rjmp_abs", {63'd0, pc_abs}, 64'd0);
        check_eq("rjmp_target", 64'(pc_target), 64'h1);
        idle(1);
        check_eq("rjmp_pulse", {63'd0, pc_redirect}, 64'd0);

        // rn aliasing: rn_wb wins over aliased reg write; alias alone writes rn
        ins = '0; ins.reg_wb = 1; ins.reg_code = 3'd7; ins.reg_val = 32'h0001_8000;
        ins.rn_wb = 1; ins.rn_val = 32'h7;
        send(ins);
        check_eq("scn_rn", 64'(rn_q), 64'h7);
        check_eq("scn_rf_we", {63'd0, rf_we}, 64'd0);
        ins = '0; ins.reg_wb = 1; ins.reg_code = 3'd7; ins.reg_val = 32'h1234;
        send(ins);
        check_eq("alias_rn", 64'(rn_q), 64'h1234);
        check_eq("alias_rf_we", {63'd0, rf_we}, 64'd0);
        idle(1);

        // Back-to-back two-write instructions: stall and wrap
        stall_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            ins = '0;
            ins.mem_wb = 1;  ins.mem_addr = 32'h200 + 32'(2 * i);     ins.mem_val = $urandom;
            ins.mem_wb2 = 1; ins.mem_addr2 = 32'h200 + 32'(2 * i + 1); ins.mem_val2 = $urandom;
            send(ins);
        end
        check_eq("ready_drop", {63'd0, stall_cnt != 0}, 64'd1);
        drain();

        // Single-write stream keeps full throughput
        stall_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            ins = '0; ins.mem_wb = 1; ins.mem_addr = 32'h300 + 32'(i); ins.mem_val = $urandom;
            send(ins);
        end
        check_eq("single_no_stall", 64'(stall_cnt), 64'd0);
        drain();

        // Randomised stream
        for (int i = 0; i < 40; i++) begin
            ins = '0;
            ins.reg_wb = 1'($urandom_range(0, 1));
            ins.reg_code = 3'($urandom_range(0, 6));
            ins.reg_val = $urandom;
            ins.mem_wb = 1'($urandom_range(0, 1));
            ins.mem_addr = $urandom; ins.mem_val = $urandom;
            ins.mem_wb2 = 1'($urandom_range(0, 1));
            ins.mem_addr2 = $urandom; ins.mem_val2 = $urandom;
            exp_we = ins.reg_wb;
            send(ins);
            check_eq("rnd_rf_we", {63'd0, rf_we}, {63'd0, exp_we});
            if (exp_we) begin
                check_eq("rnd_rf_waddr", 64'(rf_waddr), 64'(ins.reg_code));
                check_eq("rnd_rf_wdata", 64'(rf_wdata), 64'(ins.reg_val));
            end
        end
        drain();

        // Reset mid-drain: queue holds 3 entries when rst hits
        ins = '0;
        ins.mem_wb = 1;  ins.mem_addr = 32'h400; ins.mem_val = 32'h11;
        ins.mem_wb2 = 1; ins.mem_addr2 = 32'h401; ins.mem_val2 = 32'h22;
        ins.sp_wb = 1;   ins.sp_val = 32'h55;
        ins.rn_wb = 1;   ins.rn_val = 32'h66;
        send(ins);
        ins = '0;
        ins.mem_wb = 1;  ins.mem_addr = 32'h402; ins.mem_val = 32'h33;
        ins.mem_wb2 = 1; ins.mem_addr2 = 32'h403; ins.mem_val2 = 32'h44;
        send(ins);
        idle(0);
        #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        check_eq("mid_rst_we", {63'd0, dmem_we}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        check_eq("post_rst_we", {63'd0, dmem_we}, 64'd0);
        check_eq("post_rst_sp", 64'(sp_q), 64'd0);
        check_eq("post_rst_rn", 64'(rn_q), 64'd0);
        check_eq("post_rst_ready", {63'd0, in_ready}, 64'd1);
        idle(6);
        check_eq("post_rst_idle_we", {63'd0, dmem_we}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_commit.md
# wb_commit

Writeback/commit stage directly downstream of the execute stage. Each accepted execute result is committed to the architectural state: general register write port, node register `rn`, stack pointer, status register and PC redirect. Up to two data-memory writes per instruction (STEP-traverse produces two) are serialised onto the single-port data memory through a small write queue. Upstream is back-pressured when the queue cannot absorb a worst-case instruction.

## Interface
- `WORD`, 32: datapath width.
- `DEPTH`, 4: memory write queue entries (power of two, ≥2).
- `RN_CODE`, 3'd7: register code that aliases `rn`.
- `SP_RESET`, 32'h0000_0000: stack pointer reset value.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  execute result present.
- `in_ready`  out  1  stage can accept; high iff queue free entries ≥ 2.
- `reg_wb`, `reg_code`, `reg_val`  in  1/3/WORD  register write request.
- `rn_wb`, `rn_val`  in  1/WORD  node register write.
- `sp_wb`, `sp_val`  in  1/WORD  stack pointer write.
- `flag_update`, `sreg_val`  in  1/WORD  status register write.
- `mem_wb`, `mem_addr`, `mem_val`  in  1/WORD/WORD  first memory write.
- `mem_wb2`, `mem_addr2`, `mem_val2`  in  1/WORD/WORD  second memory write.
- `jump`, `rjump`, `pc_loc`, `pc_inc`  in  1/1/WORD/WORD  PC redirect request.
- `rf_we`, `rf_waddr`, `rf_wdata`  out  1/3/WORD  register file write port (registered pulse).
- `rn_q`, `sp_q`, `sreg_q`  out  WORD each  committed architectural state.
- `pc_redirect`, `pc_abs`, `pc_target`  out  1/1/WORD  one-cycle redirect pulse; `pc_abs`=1 absolute, 0 relative.
- `dmem_we`, `dmem_addr`, `dmem_wdata`  out  1/WORD/WORD  data memory write port.

## Operation
- An accept occurs at a rising edge with `in_valid && in_ready`; all request fields are ignored otherwise.
- Register path:
  - `reg_wb` with `reg_code != RN_CODE` produces `rf_we`=1, `rf_waddr`=`reg_code`, `rf_wdata`=`reg_val` for exactly one cycle.
  - `reg_wb` with `reg_code == RN_CODE` writes `rn_q` instead; `rf_we` stays 0.
  - If `rn_wb` and an rn-aliased `reg_wb` occur together, `rn_val` wins.
- `sp_wb` loads `sp_q`; `flag_update` loads `sreg_q` (full word).
- PC redirect:
  - `jump` yields `pc_redirect`=1, `pc_abs`=1, `pc_target`=`pc_loc`.
  - `rjump` alone yields `pc_abs`=0, `pc_target`=`pc_inc`.
  - `jump` has priority over `rjump`.
  - The pulse lasts one cycle.
- Memory queue:
  - Circular FIFO of {addr, data}, with read/write pointers and a 0..DEPTH count.
  - On accept, the `mem_wb` entry is pushed first, then the `mem_wb2` entry; 0, 1 or 2 pushes per accept.
  - The head is presented combinationally: `dmem_we` = count≠0, `dmem_addr`/`dmem_wdata` = head. The memory always accepts, so one entry pops per cycle while non-empty.
  - A push and a pop in the same cycle are legal; count changes by pushes−1.
  - Pointers wrap modulo DEPTH.
  - No bypass: an entry never reaches the port in its own accept cycle.
- Any `rst` assertion, including mid-drain, discards queued writes, drops all pulses and restores reset values.

## Timing
- Reset values:
  - `rf_we`=0, `rf_waddr`=0, `rf_wdata`=0.
  - `rn_q`=0, `sreg_q`=0, `sp_q`=`SP_RESET`.
  - `pc_redirect`=0, `pc_abs`=0, `pc_target`=0.
  - `dmem_we`=0, and the queue is empty.
- Accept at edge t:
  - `rf_*`, `rn_q`, `sp_q`, `sreg_q` and `pc_*` are valid in cycle t+1.
  - The first memory write is on the port in cycle t+1 if the queue was empty; the second is in cycle t+2.
- `in_ready` is combinational from count only, never from `in_valid`.
- Throughput: one instruction per cycle while each instruction issues ≤1 memory write. A two-write instruction on a full stream backs up by one cycle.
- `in_ready`=0 holds upstream. Held fields must be stable until accepted.

## Structure
- Shared package (alongside the existing format header): `WORD`, `NODE_BITS`, `NODES`, `VIS_OFFSET`, flag indices `Zf`/`Cf`/`Nf`/`If`, the `rn` register code, and the opcode constants.
- One sub-module, `wb_mem_fifo`: parameterised width/DEPTH queue with a 2-wide push and 1-wide pop, plus count output.
- `wb_commit` holds the architectural registers and the redirect logic.

## Test plan
- Reset mid-operation: queue holds 3 entries, `rst` pulses → `dmem_we`=0 next cycle, `sp_q`=`SP_RESET`, `rn_q`=0, and no stale write ever appears.
- ADDI-style accept with `reg_wb`=1, code 2, val 5 → cycle t+1: `rf_we`=1, `rf_waddr`=2, `rf_wdata`=5. Cycle t+2: `rf_we`=0.
- STEP traverse: `mem_wb` (addr 0x105, val 1), `mem_wb2` (addr 0x21, val 0x8000), `sp_wb` (sp 0x21), `rn_wb` (0x0002_8000) → t+1: write 0x105←1 on the memory port, `sp_q`=0x21, `rn_q`=0x0002_8000. t+2: write 0x21←0x8000.
- Back-to-back two-write instructions with DEPTH=4 → `in_ready` drops when free entries <2. All writes appear in push order with no loss or duplication across pointer wrap.
- `jump` and `rjump` both set, `pc_loc`=0x40, `pc_inc`=1 → single pulse with `pc_abs`=1, `pc_target`=0x40. `rjump` alone with `pc_inc`=1 → `pc_abs`=0, `pc_target`=1.
- SCN-style `reg_wb` with `reg_code`=RN_CODE, val 0x0001_8000, together with `rn_wb` val 0x7 → `rn_q`=0x7 and `rf_we` stays 0.
